// File: rtl/mem_access_stage.sv
// mem_access_stage -- MEM stage of the 16-bit pipelined MIPS.
//
// Holds the EX/MEM pipeline register and resolves branches for fetch. Loads and
// stores go through a direct-mapped, write-through, no-write-allocate data cache
// with one-word lines, backed by a slow req/ack memory. Produces the MEM/WB
// register and the global pipeline enable `hit` (low = stall upstream).
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   aluResult / read_data_2        EX result (byte address) / store data
//   write_reg_ex, branch_target    destination register, EX branch target
//   zero, branch, memRead,
//   memWrite, memtoReg, regWrite   EX flag and control bits
//   mem_req/mem_we/mem_addr/
//   mem_wdata                      backing-memory request (held until mem_ack)
//   mem_ack/mem_rdata              one-cycle completion pulse and read data
//   hit                            pipeline enable
//   pcSrc, branch_target_out       branch decision and registered target
//   wb_*                           MEM/WB register fields
module mem_access_stage #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] aluResult,
  input  logic [15:0] read_data_2,
  input  logic [2:0]  write_reg_ex,
  input  logic [15:0] branch_target,
  input  logic        zero,
  input  logic        branch,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memtoReg,
  input  logic        regWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        hit,
  output logic        pcSrc,
  output logic [15:0] branch_target_out,
  output logic [15:0] wb_read_data,
  output logic [15:0] wb_alu_result,
  output logic [2:0]  wb_write_reg,
  output logic        wb_memtoReg,
  output logic        wb_regWrite
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 15 - INDEX_BITS;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] sdata;
    logic [2:0]  wreg;
    logic [15:0] btgt;
    logic        zero;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
  } exmem_t;

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_t;

  exmem_t exmem;
  state_t state, state_nxt;

  logic [LINES-1:0]  valid;
  logic [15:0]       data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [15:0]       fill_data;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  line_hit;
  logic                  is_wr;
  logic                  is_rd;
  logic                  fill_en;
  logic                  wr_upd;

  // Address split: bit 0 is the byte select and is ignored.
  assign idx      = exmem.alu[INDEX_BITS:1];
  assign tag      = exmem.alu[15:INDEX_BITS+1];
  assign line_hit = valid[idx] && (tag_arr[idx] == tag);

  // A simultaneous read+write is treated as a write only.
  assign is_wr = exmem.mem_write;
  assign is_rd = exmem.mem_read & ~exmem.mem_write;

  assign pcSrc             = exmem.branch & exmem.zero;
  assign branch_target_out = exmem.btgt;

  // The request fields come straight from EX/MEM, which is frozen while hit=0,
  // so they stay stable for the whole request.
  assign mem_addr  = exmem.alu[15:1];
  assign mem_wdata = exmem.sdata;

  assign fill_en = (state == RD_REQ) && mem_ack;
  // No allocate on a write miss: only a resident line is refreshed.
  assign wr_upd  = (state == WR_REQ) && mem_ack && line_hit;

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem <= '0;
    end else if (hit) begin
      exmem.alu        <= aluResult;
      exmem.sdata      <= read_data_2;
      exmem.wreg       <= write_reg_ex;
      exmem.btgt       <= branch_target;
      exmem.zero       <= zero;
      exmem.branch     <= branch;
      exmem.mem_read   <= memRead;
      exmem.mem_write  <= memWrite;
      exmem.mem_to_reg <= memtoReg;
      exmem.reg_write  <= regWrite;
    end
  end

  // Miss / write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (is_wr) begin
          hit       = 1'b0;
          state_nxt = WR_REQ;
        end else if (is_rd && !line_hit) begin
          hit       = 1'b0;
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        hit     = 1'b0;
        mem_req = 1'b1;
        if (mem_ack) state_nxt = DONE;
      end
      WR_REQ: begin
        hit     = 1'b0;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valid bits are the only cache state that needs reset; data/tag of an
  // invalid line are never looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      fill_data <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      fill_data  <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_arr[idx] <= mem_rdata;
      tag_arr[idx]  <= tag;
    end else if (wr_upd) begin
      data_arr[idx] <= exmem.sdata;
    end
  end

  // MEM/WB register: a stall cycle becomes a bubble (controls cleared, data held).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_write_reg  <= '0;
      wb_memtoReg   <= 1'b0;
      wb_regWrite   <= 1'b0;
    end else if (hit) begin
      wb_read_data  <= (state == DONE) ? fill_data : data_arr[idx];
      wb_alu_result <= exmem.alu;
      wb_write_reg  <= exmem.wreg;
      wb_memtoReg   <= exmem.mem_to_reg;
      wb_regWrite   <= exmem.reg_write;
    end else begin
      wb_memtoReg   <= 1'b0;
      wb_regWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// random instructions, checked against a cache/memory reference model.
module tb_mem_access_stage;
  localparam int IB = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] aluResult, read_data_2, branch_target;
  logic [2:0]  write_reg_ex;
  logic        zero, branch, memRead, memWrite, memtoReg, regWrite;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        hit, pcSrc;
  logic [15:0] branch_target_out, wb_read_data, wb_alu_result;
  logic [2:0]  wb_write_reg;
  logic        wb_memtoReg, wb_regWrite;

  mem_access_stage #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst_n(rst_n), .aluResult(aluResult), .read_data_2(read_data_2),
    .write_reg_ex(write_reg_ex), .branch_target(branch_target), .zero(zero),
    .branch(branch), .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg),
    .regWrite(regWrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit(hit),
    .pcSrc(pcSrc), .branch_target_out(branch_target_out), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg),
    .wb_memtoReg(wb_memtoReg), .wb_regWrite(wb_regWrite)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_dly  = 3;

  // Backing memory (responder) and expected memory (model), word addressed.
  logic [15:0] bmem [int];
  logic [15:0] mmem [int];
  // Reference cache: only residency matters; write-through keeps data == memory.
  bit mvalid [1<<IB];
  int mtag   [1<<IB];

  int          last_stall;
  int          req_starts = 0;
  int          rcnt = 0;
  bit          busy = 1'b0;
  logic [14:0] lat_addr = '0;
  logic        lat_we = 1'b0;
  logic [15:0] lat_wdata = '0;

  function automatic logic [15:0] dflt(int a);
    return 16'(a * 40503 + 4660);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slow memory: acks ack_dly cycles after a request starts, whatever happens
  // to mem_req in between.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      busy    = 1'b0;
    end else begin
      if (!busy && mem_req) begin
        busy      = 1'b1;
        rcnt      = 0;
        lat_addr  = mem_addr;
        lat_we    = mem_we;
        lat_wdata = mem_wdata;
        req_starts++;
      end
      if (busy) begin
        if (mem_req && rcnt > 0) begin
          chk("req_addr_stable", mem_addr, lat_addr);
          chk("req_wdata_stable", mem_wdata, lat_wdata);
        end
        rcnt++;
        if (rcnt == ack_dly) begin
          mem_ack = 1'b1;
          if (lat_we) bmem[int'(lat_addr)] = lat_wdata;
          else mem_rdata = bmem.exists(int'(lat_addr)) ? bmem[int'(lat_addr)] : dflt(int'(lat_addr));
        end
      end
    end
  end

  task automatic drive_nop();
    aluResult = '0; read_data_2 = '0; write_reg_ex = '0; branch_target = '0;
    zero = 0; branch = 0; memRead = 0; memWrite = 0; memtoReg = 0; regWrite = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1 << IB); i++) mvalid[i] = 1'b0;
  endtask

  // Issue one instruction, follow it through any stall, check MEM/WB.
  task automatic run_instr(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] wr,
                           input logic [15:0] bt, input logic br, input logic z,
                           input logic mr, input logic mw, input logic m2r, input logic rw,
                           input string nm);
    int idx, tg, wa, stall, exp_stall, r0;
    bit is_wr, is_rd, mhit;
    logic [15:0] exp_data;
    idx = (int'(a) >> 1) % (1 << IB);
    tg  = int'(a) >> (IB + 1);
    wa  = int'(a) >> 1;
    is_wr = mw;
    is_rd = mr && !mw;
    mhit  = mvalid[idx] && (mtag[idx] == tg);
    exp_stall = (is_wr || (is_rd && !mhit)) ? ack_dly + 1 : 0;
    exp_data  = mmem.exists(wa) ? mmem[wa] : dflt(wa);
    if (is_wr) mmem[wa] = wd;
    if (is_rd && !mhit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    r0 = req_starts;

    @(negedge clk);
    aluResult = a; read_data_2 = wd; write_reg_ex = wr; branch_target = bt;
    zero = z; branch = br; memRead = mr; memWrite = mw; memtoReg = m2r; regWrite = rw;
    @(posedge clk);
    @(negedge clk);
    drive_nop();
    chk({nm, "_pcSrc"}, pcSrc, br & z);
    chk({nm, "_btgt"}, branch_target_out, bt);
    stall = 0;
    while (!hit && stall < 50) begin
      stall++;
      @(negedge clk);
    end
    last_stall = stall;
    chk({nm, "_stall"}, stall, exp_stall);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_wb_alu"}, wb_alu_result, a);
    chk({nm, "_wb_reg"}, wb_write_reg, wr);
    chk({nm, "_wb_rw"}, wb_regWrite, rw);
    chk({nm, "_wb_m2r"}, wb_memtoReg, m2r);
    if (is_rd) chk({nm, "_wb_data"}, wb_read_data, exp_data);
    chk({nm, "_nreq"}, req_starts - r0, (exp_stall != 0) ? 1 : 0);
    if (exp_stall != 0) begin
      chk({nm, "_req_addr"}, lat_addr, wa);
      chk({nm, "_req_we"}, lat_we, is_wr);
      if (is_wr) chk({nm, "_req_wdata"}, lat_wdata, wd);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rwd, rbt;
    logic [2:0]  rreg;
    clear_model();
    drive_nop();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pcSrc", pcSrc, 0);
    chk("rst_hit", hit, 1);
    chk("rst_wb_data", wb_read_data, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_reg", wb_write_reg, 0);
    chk("rst_wb_ctl", {wb_memtoReg, wb_regWrite}, 0);
    rst_n = 1'b1;

    // 1) load miss
    ack_dly = 3;
    bmem[8] = 16'hBEEF;
    mmem[8] = 16'hBEEF;
    run_instr(16'h0010, 16'h0, 3'd2, 16'h0, 0, 0, 1, 0, 1, 1, "t1");
    chk("t1_hit_low", last_stall, 4);
    chk("t1_addr", lat_addr, 15'h0008);
    chk("t1_data", wb_read_data, 16'hBEEF);

    // 2) load hit
    run_instr(16'h0010, 16'h0, 3'd3, 16'h0, 0, 0, 1, 0, 1, 1, "t2");
    chk("t2_hit_low", last_stall, 0);
    chk("t2_data", wb_read_data, 16'hBEEF);

    // 3) store to a cached line, then load it back
    run_instr(16'h0010, 16'h1234, 3'd0, 16'h0, 0, 0, 0, 1, 0, 0, "t3s");
    chk("t3_we", lat_we, 1);
    chk("t3_wdata", lat_wdata, 16'h1234);
    run_instr(16'h0010, 16'h0, 3'd4, 16'h0, 0, 0, 1, 0, 1, 1, "t3l");
    chk("t3_hit_low", last_stall, 0);
    chk("t3_data", wb_read_data, 16'h1234);

    // 4) conflict on the same index
    run_instr(16'h0030, 16'h0, 3'd5, 16'h0, 0, 0, 1, 0, 1, 1, "t4a");
    chk("t4a_miss", last_stall, ack_dly + 1);
    run_instr(16'h0010, 16'h0, 3'd6, 16'h0, 0, 0, 1, 0, 1, 1, "t4b");
    chk("t4b_miss", last_stall, ack_dly + 1);
    chk("t4b_data", wb_read_data, 16'h1234);

    // 5) branch resolution
    run_instr(16'h0000, 16'h0, 3'd0, 16'h0040, 1, 1, 0, 0, 0, 0, "t5a");
    run_instr(16'h0001, 16'h0, 3'd0, 16'h0040, 1, 0, 0, 0, 0, 0, "t5b");

    // 6) reset during a read request; the late ack must be ignored
    ack_dly = 3;
    @(negedge clk);
    aluResult = 16'h0050; memRead = 1; memtoReg = 1; regWrite = 1; write_reg_ex = 3'd1;
    @(posedge clk);
    @(negedge clk);
    drive_nop();
    @(negedge clk);
    #2;
    chk("t6_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_drop", mem_req, 0);
    chk("t6_hit", hit, 1);
    clear_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_req_idle", mem_req, 0);
    chk("t6_hit_idle", hit, 1);
    run_instr(16'h0050, 16'h0, 3'd1, 16'h0, 0, 0, 1, 0, 1, 1, "t6a");
    chk("t6a_miss", last_stall, ack_dly + 1);
    run_instr(16'h0010, 16'h0, 3'd2, 16'h0, 0, 0, 1, 0, 1, 1, "t6b");
    chk("t6b_miss", last_stall, ack_dly + 1);

    // Random traffic over a few tags so hits, conflicts and write misses all occur.
    for (int i = 0; i < 150; i++) begin
      ack_dly = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
      else ra = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      rwd  = 16'($urandom);
      rbt  = 16'($urandom);
      rreg = 3'($urandom_range(0, 7));
      run_instr(ra, rwd, rreg, rbt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
